// File: rtl/mb_pipe_ctrl.sv
// rtl/mb_pipe_ctrl.sv - macroblock pipeline controller: fill/steady/drain sequencing of NUM_STAGES stages
module mb_pipe_ctrl #(
    parameter int NUM_STAGES   = 3,
    parameter int PIC_W_MB_LEN = 8,
    parameter int PIC_H_MB_LEN = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 sys_start,
    input  logic                                 sys_abort,
    input  logic                                 sys_mode,
    input  logic [PIC_W_MB_LEN-1:0]              sys_x_total,
    input  logic [PIC_H_MB_LEN-1:0]              sys_y_total,
    input  logic [NUM_STAGES-1:0]                stage_done_i,
    input  logic                                 bs_empty_i,
    output logic                                 sys_done,
    output logic [NUM_STAGES-1:0]                stage_start_o,
    output logic                                 frame_start_o,
    output logic                                 frame_done_o,
    output logic [NUM_STAGES*PIC_W_MB_LEN-1:0]   mb_x_o,
    output logic [NUM_STAGES*PIC_H_MB_LEN-1:0]   mb_y_o
);

    typedef enum logic [1:0] {IDLE, INIT, RUN, STORE} state_t;

    state_t                     state;
    logic [PIC_W_MB_LEN-1:0]    xt_q;
    logic [PIC_H_MB_LEN-1:0]    yt_q;
    logic [NUM_STAGES-1:0]      valid;
    logic [NUM_STAGES-1:0]      flag;
    logic [NUM_STAGES-1:0]      done_d;
    logic [NUM_STAGES-1:0]      done_rise;
    logic [NUM_STAGES-1:0]      flag_ok;
    logic [NUM_STAGES-1:0]      valid_nxt;
    logic [PIC_W_MB_LEN-1:0]    idx_x [NUM_STAGES];
    logic [PIC_H_MB_LEN-1:0]    idx_y [NUM_STAGES];
    logic                       kick;
    logic                       advance;
    logic                       s0_last;

    assign done_rise = stage_done_i & ~done_d;
    assign s0_last   = (idx_x[0] == xt_q) && (idx_y[0] == yt_q);
    assign flag_ok   = ~valid | flag;
    assign advance   = (state == RUN) && !sys_abort && (valid != '0) && (&flag_ok)
                       && (sys_mode ? sys_start : 1'b1);
    // Stage 0 stops taking new MBs once it holds the last one; the rest shift down the pipe.
    assign valid_nxt = {valid[NUM_STAGES-2:0], ~s0_last};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            xt_q          <= '0;
            yt_q          <= '0;
            valid         <= '0;
            flag          <= '0;
            done_d        <= '0;
            kick          <= 1'b0;
            sys_done      <= 1'b1;
            stage_start_o <= '0;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                idx_x[k] <= '0;
                idx_y[k] <= '0;
            end
        end else begin
            done_d        <= stage_done_i;
            kick          <= 1'b0;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            // valid was updated on the kick edge, so this launches the freshly shifted set.
            stage_start_o <= kick ? valid : '0;
            if (state != IDLE && sys_abort) begin
                state         <= IDLE;
                sys_done      <= 1'b1;
                valid         <= '0;
                flag          <= '0;
                stage_start_o <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sys_start) begin
                            state    <= INIT;
                            sys_done <= 1'b0;
                        end
                    end
                    INIT: begin
                        xt_q          <= sys_x_total;
                        yt_q          <= sys_y_total;
                        valid         <= NUM_STAGES'(1);
                        idx_x[0]      <= '0;
                        idx_y[0]      <= '0;
                        flag          <= '0;
                        kick          <= 1'b1;
                        frame_start_o <= 1'b1;
                        state         <= RUN;
                    end
                    RUN: begin
                        flag <= (advance ? '0 : flag) | (done_rise & valid);
                        if (advance) begin
                            valid <= valid_nxt;
                            kick  <= 1'b1;
                            for (int k = 1; k < NUM_STAGES; k++) begin
                                idx_x[k] <= idx_x[k-1];
                                idx_y[k] <= idx_y[k-1];
                            end
                            if (!s0_last) begin
                                if (idx_x[0] == xt_q) begin
                                    idx_x[0] <= '0;
                                    idx_y[0] <= idx_y[0] + 1'b1;
                                end else begin
                                    idx_x[0] <= idx_x[0] + 1'b1;
                                end
                            end
                            if (valid_nxt == '0) begin
                                state        <= STORE;
                                frame_done_o <= 1'b1;
                            end
                        end
                    end
                    STORE: begin
                        if (bs_empty_i && (sys_mode ? sys_start : 1'b1)) begin
                            state    <= IDLE;
                            sys_done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_idx_out
        assign mb_x_o[k*PIC_W_MB_LEN +: PIC_W_MB_LEN] = idx_x[k];
        assign mb_y_o[k*PIC_H_MB_LEN +: PIC_H_MB_LEN] = idx_y[k];
    end

endmodule

// File: tb/tb_mb_pipe_ctrl.sv
// tb/tb_mb_pipe_ctrl.sv - scoreboard bench for mb_pipe_ctrl with 3-stage and 5-stage instances
module tb_mb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sys_abort, sys_mode, bs_empty, start3, start5;
    logic [7:0]  sys_x_total, sys_y_total;
    logic [2:0]  done3, st3;
    logic [4:0]  done5, st5;
    logic        sd3, sd5, fs3, fs5, fd3, fd5;
    logic [23:0] x3, y3;
    logic [39:0] x5, y5;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cnt [2][5];
    int nstarts [2][5];
    int ndone [2][5];
    int start_cyc [2][5];
    int done_cyc [2][5];
    int start_cycles [2];
    int fd_cnt [2];
    int fs_cnt [2];
    int frame_total [2];
    int lat_min = 5;
    int lat_max = 5;
    bit spur_en = 1'b0;
    logic [15:0] sb_q [10][$];

    mb_pipe_ctrl #(.NUM_STAGES(3), .PIC_W_MB_LEN(8), .PIC_H_MB_LEN(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .sys_start(start3), .sys_abort(sys_abort), .sys_mode(sys_mode),
        .sys_x_total(sys_x_total), .sys_y_total(sys_y_total), .stage_done_i(done3), .bs_empty_i(bs_empty),
        .sys_done(sd3), .stage_start_o(st3), .frame_start_o(fs3), .frame_done_o(fd3),
        .mb_x_o(x3), .mb_y_o(y3)
    );

    mb_pipe_ctrl #(.NUM_STAGES(5), .PIC_W_MB_LEN(8), .PIC_H_MB_LEN(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .sys_start(start5), .sys_abort(sys_abort), .sys_mode(sys_mode),
        .sys_x_total(sys_x_total), .sys_y_total(sys_y_total), .stage_done_i(done5), .bs_empty_i(bs_empty),
        .sys_done(sd5), .stage_start_o(st5), .frame_start_o(fs5), .frame_done_o(fd5),
        .mb_x_o(x5), .mb_y_o(y5)
    );

    task automatic mon(input int d, input int n, input logic [4:0] st, input logic [39:0] xs,
                       input logic [39:0] ys, input logic fs, input logic fd);
        logic [15:0] got, exp;
        if (st != '0) start_cycles[d]++;
        fs_cnt[d] += int'(fs);
        fd_cnt[d] += int'(fd);
        for (int k = 0; k < n; k++) begin
            if (st[k]) begin
                nstarts[d][k]++;
                start_cyc[d][k] = cyc;
                got = {xs[k*8 +: 8], ys[k*8 +: 8]};
                checks++;
                if (sb_q[d*5+k].size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_start d%0d s%0d: got x=%0d y=%0d expected no start",
                             d, k, got[15:8], got[7:0]);
                end else begin
                    exp = sb_q[d*5+k].pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL sb_index d%0d s%0d: got x=%0d y=%0d expected x=%0d y=%0d",
                                 d, k, got[15:8], got[7:0], exp[15:8], exp[7:0]);
                    end
                end
            end
        end
    endtask

    task automatic resp(input int d, input int n, input logic [4:0] st, output logic [4:0] dn);
        bit finished, unstarted;
        dn = '0;
        for (int k = 0; k < n; k++) begin
            if (st[k]) begin
                checks++;
                if (cnt[d][k] != 0) begin
                    errors++;
                    $display("FAIL start_while_busy d%0d s%0d: got start with %0d cycles left expected idle",
                             d, k, cnt[d][k]);
                end
            end
            finished  = (nstarts[d][k] == frame_total[d]) && (ndone[d][k] == frame_total[d]);
            unstarted = (k > 0) && (nstarts[d][k] == 0) && (ndone[d][k-1] == 0);
            if (cnt[d][k] > 0) begin
                cnt[d][k]--;
                if (cnt[d][k] == 0) begin
                    dn[k] = 1'b1;
                    ndone[d][k]++;
                    done_cyc[d][k] = cyc;
                end
            end else if (spur_en && d == 1 && (finished || unstarted) && $urandom_range(0, 7) == 0) begin
                dn[k] = 1'b1;
            end
            if (st[k]) cnt[d][k] = int'($urandom_range(lat_min, lat_max));
        end
    endtask

    task automatic tick();
        logic [4:0] dn;
        @(negedge clk);
        cyc++;
        mon(0, 3, {2'b00, st3}, {16'h0, x3}, {16'h0, y3}, fs3, fd3);
        mon(1, 5, st5, x5, y5, fs5, fd5);
        resp(0, 3, {2'b00, st3}, dn);
        done3 = dn[2:0];
        resp(1, 5, st5, dn);
        done5 = dn;
    endtask

    task automatic start_frame(input int d, input int xt, input int yt);
        int n = (d == 0) ? 3 : 5;
        for (int k = 0; k < 5; k++) begin
            nstarts[d][k] = 0;
            ndone[d][k]   = 0;
        end
        frame_total[d] = (xt + 1) * (yt + 1);
        for (int k = 0; k < n; k++)
            for (int y = 0; y <= yt; y++)
                for (int x = 0; x <= xt; x++)
                    sb_q[d*5+k].push_back({8'(x), 8'(y)});
        sys_x_total = 8'(xt);
        sys_y_total = 8'(yt);
        if (d == 0) start3 = 1'b1;
        else        start5 = 1'b1;
        tick();
        start3 = 1'b0;
        start5 = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((d == 0 ? sd3 : sd5) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (sd3 !== 1'b1)   begin errors++; $display("FAIL reset_sys_done3: got %b expected 1", sd3); end
        checks++; if (sd5 !== 1'b1)   begin errors++; $display("FAIL reset_sys_done5: got %b expected 1", sd5); end
        checks++; if (st3 !== 3'b000) begin errors++; $display("FAIL reset_starts: got %b expected 000", st3); end
        checks++; if ({fs3, fd3} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {fs3, fd3}); end
        checks++; if ({x3, y3} !== 48'h0) begin errors++; $display("FAIL reset_idx: got %h expected 0", {x3, y3}); end
    endtask

    task automatic test_frame();
        bit ok;
        int fd0 = fd_cnt[0], fs0 = fs_cnt[0];
        start_frame(0, 1, 1);
        checks++; if (sd3 !== 1'b0) begin errors++; $display("FAIL frame_busy: got sys_done=%b expected 0", sd3); end
        tick();
        sys_x_total = 8'd5;
        sys_y_total = 8'd5;
        wait_idle(0, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_timeout: got busy expected sys_done=1"); end
        checks++; if (fd_cnt[0] - fd0 != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", fd_cnt[0] - fd0); end
        checks++; if (fs_cnt[0] - fs0 != 1) begin errors++; $display("FAIL frame_start_count: got %0d expected 1", fs_cnt[0] - fs0); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (nstarts[0][k] != 4) begin
                errors++; $display("FAIL frame_starts s%0d: got %0d expected 4", k, nstarts[0][k]);
            end
        end
    endtask

    task automatic test_single_mb();
        bit ok;
        int sc0 = start_cycles[0];
        start_frame(0, 0, 0);
        wait_idle(0, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got busy expected sys_done=1"); end
        checks++; if (start_cycles[0] - sc0 != 3) begin errors++; $display("FAIL single_start_cycles: got %0d expected 3", start_cycles[0] - sc0); end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (start_cyc[0][k] <= done_cyc[0][k-1]) begin
                errors++; $display("FAIL single_overlap s%0d: got start at %0d expected after %0d", k, start_cyc[0][k], done_cyc[0][k-1]);
            end
        end
    endtask

    task automatic test_step_mode();
        int sc, fd0;
        sys_mode = 1'b1;
        start_frame(0, 2, 0);
        sc = start_cycles[0];
        repeat (49) tick();
        checks++; if (start_cycles[0] - sc != 1) begin errors++; $display("FAIL step_initial: got %0d start cycles expected 1", start_cycles[0] - sc); end
        for (int p = 1; p <= 5; p++) begin
            sc  = start_cycles[0];
            fd0 = fd_cnt[0];
            start3 = 1'b1;
            tick();
            start3 = 1'b0;
            repeat (49) tick();
            checks++;
            if (start_cycles[0] - sc != (p <= 4 ? 1 : 0)) begin
                errors++; $display("FAIL step_pulse%0d: got %0d start cycles expected %0d", p, start_cycles[0] - sc, (p <= 4 ? 1 : 0));
            end
            checks++;
            if (fd_cnt[0] - fd0 != (p == 5 ? 1 : 0)) begin
                errors++; $display("FAIL step_frame_done%0d: got %0d expected %0d", p, fd_cnt[0] - fd0, (p == 5 ? 1 : 0));
            end
        end
        checks++; if (sd3 !== 1'b0) begin errors++; $display("FAIL step_store_wait: got sys_done=%b expected 0", sd3); end
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        checks++; if (sd3 !== 1'b1) begin errors++; $display("FAIL step_store_exit: got sys_done=%b expected 1", sd3); end
        sys_mode = 1'b0;
        tick();
    endtask

    task automatic test_store_hold();
        bit seen = 1'b0;
        int fd0 = fd_cnt[0], bad = 0;
        bs_empty = 1'b0;
        start_frame(0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (fd_cnt[0] != fd0) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL store_timeout: got no frame_done expected one"); end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sd3 !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL store_hold: got %0d idle cycles expected 0", bad); end
        bs_empty = 1'b1;
        tick();
        checks++; if (sd3 !== 1'b1) begin errors++; $display("FAIL store_release: got sys_done=%b expected 1", sd3); end
    endtask

    task automatic test_abort();
        bit ok;
        bit seen = 1'b0;
        int base, sc, fd0;
        start_frame(0, 1, 1);
        base = start_cycles[0];
        for (int i = 0; i < 300; i++) begin
            tick();
            if (start_cycles[0] == base + 4) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL abort_setup: got %0d start cycles expected 4", start_cycles[0] - base); end
        sys_abort = 1'b1;
        tick();
        sys_abort = 1'b0;
        checks++; if (sd3 !== 1'b1) begin errors++; $display("FAIL abort_idle: got sys_done=%b expected 1", sd3); end
        for (int k = 0; k < 3; k++) sb_q[k].delete();
        sc  = start_cycles[0];
        fd0 = fd_cnt[0];
        repeat (60) tick();
        checks++; if (start_cycles[0] != sc) begin errors++; $display("FAIL abort_starts: got %0d expected 0", start_cycles[0] - sc); end
        checks++; if (fd_cnt[0] != fd0) begin errors++; $display("FAIL abort_frame_done: got %0d expected 0", fd_cnt[0] - fd0); end
        start_frame(0, 0, 0);
        wait_idle(0, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_restart_timeout: got busy expected sys_done=1"); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sb_q[k].size() != 0) begin errors++; $display("FAIL abort_restart_left s%0d: got %0d expected 0", k, sb_q[k].size()); end
        end
    endtask

    task automatic test_async_reset();
        start_frame(0, 1, 1);
        repeat (10) tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (sd3 !== 1'b1)  begin errors++; $display("FAIL areset_done: got %b expected 1", sd3); end
        checks++; if (st3 !== 3'b0)  begin errors++; $display("FAIL areset_starts: got %b expected 000", st3); end
        checks++; if (x3 !== 24'h0)  begin errors++; $display("FAIL areset_idx: got %h expected 0", x3); end
        for (int k = 0; k < 3; k++) sb_q[k].delete();
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
    endtask

    task automatic test_random_n5();
        bit ok;
        int fd0 = fd_cnt[1];
        lat_min = 1;
        lat_max = 20;
        spur_en = 1'b1;
        start_frame(1, 3, 1);
        wait_idle(1, 3000, ok);
        spur_en = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL n5_timeout: got busy expected sys_done=1"); end
        checks++; if (fd_cnt[1] - fd0 != 1) begin errors++; $display("FAIL n5_frame_done: got %0d expected 1", fd_cnt[1] - fd0); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (nstarts[1][k] != 8) begin errors++; $display("FAIL n5_starts s%0d: got %0d expected 8", k, nstarts[1][k]); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sys_abort = 1'b0;
        sys_mode = 1'b0;
        bs_empty = 1'b1;
        start3 = 1'b0;
        start5 = 1'b0;
        sys_x_total = 8'd0;
        sys_y_total = 8'd0;
        done3 = '0;
        done5 = '0;
        test_reset();
        test_frame();
        test_single_mb();
        test_step_mode();
        test_store_hold();
        test_abort();
        test_async_reset();
        test_random_n5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
